// File: rtl/goldschmidt_prescale_if.sv
// Operand/result stream bundle for the Goldschmidt prescale stage.
// master drives operands and consumes results; slave is the stage itself.
interface goldschmidt_prescale_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic [SHW-1:0]     msb_pos;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] n_out;
    logic [WIDTH-1:0]   d_out;
    logic [SHW-1:0]     shift;
    logic               dz;

    modport master (
        output in_valid, dividend, divisor, msb_pos, out_ready,
        input  in_ready, out_valid, n_out, d_out, shift, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, msb_pos, out_ready,
        output in_ready, out_valid, n_out, d_out, shift, dz
    );
endinterface

// File: rtl/goldschmidt_prescale.sv
// Two-stage normaliser: shifts divisor MSB to bit WIDTH-1 and the
// dividend by the same amount into a double-width exact result.
module goldschmidt_prescale #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    goldschmidt_prescale_if.slave bus
);
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_n;
    logic [WIDTH-1:0]   r_s1_d;
    logic [SHW-1:0]     r_s1_sh;
    logic               r_s1_dz;

    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_n_out;
    logic [WIDTH-1:0]   r_d_out;
    logic [SHW-1:0]     r_shift;
    logic               r_dz;

    logic               w_adv1;
    logic               w_adv2;
    logic [2*WIDTH-1:0] w_n_ext;

    assign w_adv2  = !r_out_valid || bus.out_ready;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign w_n_ext = {{WIDTH{1'b0}}, r_s1_n};

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_out_valid;
    assign bus.n_out     = r_n_out;
    assign bus.d_out     = r_d_out;
    assign bus.shift     = r_shift;
    assign bus.dz        = r_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_n     <= '0;
            r_s1_d     <= '0;
            r_s1_sh    <= '0;
            r_s1_dz    <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_n  <= bus.dividend;
                r_s1_d  <= bus.divisor;
                r_s1_sh <= SHW'(WIDTH - 1) - bus.msb_pos;
                r_s1_dz <= (bus.divisor == '0);
            end
        end
    end

    // Result registers only move when downstream can take them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_n_out     <= '0;
            r_d_out     <= '0;
            r_shift     <= '0;
            r_dz        <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_n_out <= w_n_ext << r_s1_sh;
                r_d_out <= r_s1_d << r_s1_sh;
                r_shift <= r_s1_sh;
                r_dz    <= r_s1_dz;
            end
        end
    end
endmodule

// File: tb/tb_goldschmidt_prescale.sv
// Directed bench for goldschmidt_prescale: reference vectors, streaming,
// backpressure and asynchronous reset with data in flight.
module tb_goldschmidt_prescale;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    goldschmidt_prescale_if #(.WIDTH(32), .SHW(5)) bus ();

    goldschmidt_prescale #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] n,
                         input logic [31:0] d, input logic [4:0] m);
        bus.in_valid = v;
        bus.dividend = n;
        bus.divisor  = d;
        bus.msb_pos  = m;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] n,
                           input logic [31:0] d, input logic [4:0] sh,
                           input logic z);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".n"}, bus.n_out, n);
        chk({tag, ".d"}, 64'(bus.d_out), 64'(d));
        chk({tag, ".sh"}, 64'(bus.shift), 64'(sh));
        chk({tag, ".dz"}, 64'(bus.dz), 64'(z));
    endtask

    task automatic single(input string tag, input logic [31:0] n,
                          input logic [31:0] d, input logic [4:0] m,
                          input logic [63:0] en, input logic [31:0] ed,
                          input logic [4:0] es, input logic ez);
        drive(1'b1, n, d, m);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        chk({tag, ".lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk_out(tag, en, ed, es, ez);
        @(negedge clk);
        chk({tag, ".drain"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("rst.ov", 64'(bus.out_valid), 64'd0);
        chk("rst.n", bus.n_out, 64'd0);
        chk("rst.d", 64'(bus.d_out), 64'd0);
        chk("rst.sh", 64'(bus.shift), 64'd0);
        chk("rst.dz", 64'(bus.dz), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.ir", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        single("div1", 32'h3, 32'h1, 5'd0,
               64'h0000_0001_8000_0000, 32'h8000_0000, 5'd31, 1'b0);
        single("divtop", 32'hFFFF_FFFF, 32'h8000_0000, 5'd31,
               64'h0000_0000_FFFF_FFFF, 32'h8000_0000, 5'd0, 1'b0);
        single("div0", 32'h5, 32'h0, 5'd0,
               64'h0000_0002_8000_0000, 32'h0, 5'd31, 1'b1);

        // Back-to-back stream of divisors 1<<k
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                int k;
                k = c - 2;
                chk_out($sformatf("strm%0d", k),
                        64'(k + 1) << (31 - k), 32'h8000_0000,
                        5'(31 - k), 1'b0);
            end
            if (c < 8) drive(1'b1, 32'(c + 1), 32'd1 << c, 5'(c));
            else drive(1'b0, 32'd0, 32'd0, 5'd0);
            @(negedge clk);
        end
        chk("strm.end", 64'(bus.out_valid), 64'd0);

        // Backpressure for 5 cycles
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h10, 5'd4);
        #1;
        chk("bp.ir0", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("bp.ir1", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'hDEAD_BEEF, 32'h3, 5'd1);
        @(negedge clk);
        chk("bp.ir2", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd28);
        chk_out("bp.hA2", 64'h0000_0000_8800_0000, 32'h8000_0000,
                5'd27, 1'b0);
        @(negedge clk);
        chk("bp.ir3", 64'(bus.in_ready), 64'd0);
        chk_out("bp.hA3", 64'h0000_0000_8800_0000, 32'h8000_0000,
                5'd27, 1'b0);
        @(negedge clk);
        chk("bp.ir4", 64'(bus.in_ready), 64'd0);
        chk_out("bp.hA4", 64'h0000_0000_8800_0000, 32'h8000_0000,
                5'd27, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.rel", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        chk_out("bp.B", 64'h37AB_6FBB_C000_0000, 32'hC000_0000,
                5'd30, 1'b0);
        @(negedge clk);
        chk_out("bp.C", 64'h0000_0007_FFFF_FFF8, 32'h91A2_B3C0,
                5'd3, 1'b0);
        @(negedge clk);
        chk("bp.end", 64'(bus.out_valid), 64'd0);

        // Async reset with two pairs in flight
        drive(1'b1, 32'h7, 32'h9, 5'd3);
        @(negedge clk);
        drive(1'b1, 32'h8, 32'hA, 5'd3);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        chk("ar.pre", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("ar.ov", 64'(bus.out_valid), 64'd0);
        chk("ar.n", bus.n_out, 64'd0);
        chk("ar.ir", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ar.stale%0d", i), 64'(bus.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
